conv_layer_sequencer: RTL and testbench

Frame-level controller for one convolution featuremap layer. On `start` it streams one IMG_SIZE x IMG_SIZE input frame from the layer input buffer into the featuremap datapath, one packed multi-channel pixel per read. It then counts the datapath's output pixels and generates output-buffer write addresses. It reports completion, or a drain timeout, to the network-level scheduler.

---
 rtl/conv_layer_sequencer.sv | 121 ++++++++++++
 tb/tb_conv_layer_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer.sv
// Frame-level sequencer for one convolution featuremap layer: streams the input frame into
// the datapath, turns datapath outputs into output-buffer writes and reports done or timeout.
module conv_layer_sequencer #(
  parameter int unsigned IMG_SIZE      = 104,
  parameter int unsigned OUT_SIZE      = 104,
  parameter int unsigned ADDR_WIDTH    = 14,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  parameter int unsigned TO_WIDTH      = 11
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_avail,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  fm_valid_in,
  input  logic                  fm_valid_out,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  localparam logic [ADDR_WIDTH-1:0] LastIn    = ADDR_WIDTH'(IMG_SIZE * IMG_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] LastOut   = ADDR_WIDTH'(OUT_SIZE * OUT_SIZE - 1);
  // The counter reaches DRAIN_TIMEOUT-1 on the edge that leaves it at this value + 1.
  localparam logic [TO_WIDTH-1:0]   ExpireCnt = TO_WIDTH'(DRAIN_TIMEOUT - 2);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain, StFin} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
  logic                  err_q, err_d;
  logic                  fm_valid_in_q;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    to_cnt_d  = '0;
    err_d     = err_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFeed;
          err_d   = 1'b0;
        end
      end
      StFeed: begin
        rd_en = in_avail;
        wr_en = fm_valid_out;
        // An over-early datapath can finish the output frame while still feeding.
        if (wr_en && (wr_addr_q == LastOut)) begin
          state_d = StFin;
        end else if (rd_en && (rd_addr_q == LastIn)) begin
          state_d = StDrain;
        end
        if (rd_en && (rd_addr_q != LastIn)) rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
        if (wr_en && (wr_addr_q != LastOut)) wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
      end
      StDrain: begin
        wr_en = fm_valid_out;
        if (wr_en) begin
          if (wr_addr_q == LastOut) state_d = StFin;
          else wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
        end else if (to_cnt_q == ExpireCnt) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_WIDTH'(1);
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      err_d   = err_q;
    end

    if (state_d == StIdle) begin
      rd_addr_d = '0;
      wr_addr_d = '0;
      to_cnt_d  = '0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= StIdle;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      to_cnt_q      <= '0;
      err_q         <= 1'b0;
      fm_valid_in_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_q     <= wr_addr_d;
      to_cnt_q      <= to_cnt_d;
      err_q         <= err_d;
      fm_valid_in_q <= rd_en;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign wr_addr     = wr_addr_q;
  assign fm_valid_in = fm_valid_in_q;
  assign busy        = (state_q == StFeed) || (state_q == StDrain);
  assign done        = (state_q == StFin);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer on a 4x4 frame: a count-based frame model plus a delayed
// datapath model check every cycle under directed and randomized stimulus.
module tb_conv_layer_sequencer;

  localparam int unsigned Img  = 4;
  localparam int unsigned Aw   = 4;
  localparam int unsigned Dt   = 8;
  localparam int unsigned Tw   = 4;
  localparam int          NPix = Img * Img;
  localparam int          Lat  = 3;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start, abort, in_avail, fm_valid_out;
  logic          rd_en, fm_valid_in, wr_en, busy, done, timeout_err;
  logic [Aw-1:0] rd_addr, wr_addr;

  conv_layer_sequencer #(
    .IMG_SIZE     (Img),
    .OUT_SIZE     (Img),
    .ADDR_WIDTH   (Aw),
    .DRAIN_TIMEOUT(Dt),
    .TO_WIDTH     (Tw)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .start       (start),
    .abort       (abort),
    .in_avail    (in_avail),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .fm_valid_in (fm_valid_in),
    .fm_valid_out(fm_valid_out),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Frame model: progress kept as pixel counts, not as controller state.
  bit m_active, m_feeding, m_fin, m_err, m_prev_rd;
  int m_reads, m_writes, m_gap, m_vin;
  bit sched [0:1023];

  task automatic reset_model();
    m_active  = 0;
    m_feeding = 0;
    m_fin     = 0;
    m_err     = 0;
    m_prev_rd = 0;
    m_reads   = 0;
    m_writes  = 0;
    m_gap     = 0;
    m_vin     = 0;
    foreach (sched[i]) sched[i] = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, timeout_err, 0);
    check({tag, "_vin"}, fm_valid_in, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
  endtask

  // stall: 0 always available, 1 pattern 1,0,0,1, 2 random. drop_n: final outputs lost.
  // extra_last: added latency of the final output. abort_at: read count at which to abort.
  // rst_at: frame cycle at which to pulse reset between edges.
  task automatic run_frame(input int stall, input int drop_n, input int extra_last,
                           input int abort_at, input int rst_at, input bit spam,
                           input bit start_abort);
    int  cyc = 0;
    int  idle_run = 0;
    bit  aborted = 0;
    bit  e_rd, e_wr, idle, drain, fin_next;
    foreach (sched[i]) sched[i] = 0;
    while (1) begin
      if (Rst) Rst = 1'b0;
      idle  = !m_active && !m_fin;
      start = 1'b0;
      abort = 1'b0;
      if (cyc == 0) begin
        start = 1'b1;
        abort = start_abort;
      end else if (cyc == 1 && start_abort) begin
        start = 1'b1;
      end else if (spam && m_active) begin
        start = ($urandom_range(0, 2) == 0);
      end
      case (stall)
        0:       in_avail = 1'b1;
        1:       in_avail = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: in_avail = ($urandom_range(0, 2) != 0);
      endcase
      if (abort_at >= 0 && !aborted && m_active && m_feeding && m_reads == abort_at) begin
        abort   = 1'b1;
        aborted = 1;
      end
      fm_valid_out = sched[cyc];
      #1;
      e_rd = m_active && m_feeding && in_avail;
      e_wr = m_active && fm_valid_out;
      check("busy", busy, m_active);
      check("done", done, m_fin);
      check("timeout_err", timeout_err, m_err);
      check("rd_en", rd_en, e_rd);
      check("wr_en", wr_en, e_wr);
      check("fm_valid_in", fm_valid_in, m_prev_rd);
      if (e_rd) check("rd_addr", rd_addr, m_reads);
      if (e_wr) check("wr_addr", wr_addr, m_writes);
      if (idle) begin
        check("idle_rd_addr", rd_addr, 0);
        check("idle_wr_addr", wr_addr, 0);
      end

      // Datapath: every valid_in returns Lat cycles later unless it is among the dropped.
      if (m_prev_rd) begin
        if (m_vin < NPix - drop_n)
          sched[cyc + Lat + ((m_vin == NPix - 1) ? extra_last : 0)] = 1;
        m_vin++;
      end

      m_prev_rd = e_rd;
      fin_next  = 0;
      if (abort) begin
        m_active = 0;
      end else if (m_active) begin
        drain = !m_feeding;
        if (e_wr) begin
          m_writes++;
          if (m_writes == NPix) begin
            m_active = 0;
            fin_next = 1;
          end
        end
        if (m_active && e_rd) begin
          m_reads++;
          if (m_reads == NPix) m_feeding = 0;
        end
        if (m_active && drain) begin
          if (fm_valid_out) m_gap = 0;
          else begin
            m_gap++;
            if (m_gap == Dt - 1) begin
              m_err    = 1;
              m_active = 0;
            end
          end
        end
      end else if (idle && start) begin
        m_active  = 1;
        m_feeding = 1;
        m_reads   = 0;
        m_writes  = 0;
        m_gap     = 0;
        m_vin     = 0;
        m_err     = 0;
      end
      m_fin = fin_next;

      if (cyc == rst_at) begin
        #2 Rst = 1'b1;
        #1 check_all_zero("async_rst");
        reset_model();
      end

      idle_run = (m_active || m_fin) ? 0 : idle_run + 1;
      cyc++;
      @(posedge Clk);
      #1;
      if (idle_run >= 16 && cyc > 2) break;
      if (cyc >= 400) begin
        check("frame_bound", idle_run, 16);
        break;
      end
    end
  endtask

  initial begin
    Rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    in_avail     = 1'b0;
    fm_valid_out = 1'b0;
    reset_model();
    @(posedge Clk);
    #1 check_all_zero("reset");
    Rst = 1'b0;
    @(posedge Clk);
    #1;

    run_frame(0, 0, 0, -1, -1, 0, 0);  // normal frame
    run_frame(1, 0, 0, -1, -1, 0, 0);  // input stalls
    run_frame(0, 2, 0, -1, -1, 0, 0);  // drain timeout
    run_frame(0, 0, 0, 5, -1, 0, 0);   // start clears error, then abort at rd_addr 5
    run_frame(0, 0, 0, -1, -1, 0, 0);  // restart from 0
    run_frame(0, 0, 0, -1, 19, 0, 0);  // reset mid-drain
    run_frame(0, 0, 0, -1, -1, 0, 0);  // full frame after reset
    run_frame(0, 0, 0, -1, -1, 1, 1);  // start+abort in idle, start spam while busy
    run_frame(0, 0, 6, -1, -1, 0, 0);  // last write on the expiry cycle wins
    run_frame(0, 0, 7, -1, -1, 0, 0);  // one cycle later: timeout

    for (int i = 0; i < 10; i++) begin
      run_frame(2, $urandom_range(0, 1), $urandom_range(0, 8),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NPix - 1)) : -1,
                -1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
